// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bundle: event inputs from the pipeline and
// stall/flush/redirect controls back to it. The controller uses the slave side.
interface hazard_ctrl_if;
    logic        raw_conflict;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        ex_redirect;
    logic        trap_req;
    logic        perf_clr;

    logic        stall_pc;
    logic        stall_if2;
    logic        stall_id;
    logic        stall_ex;
    logic        stall_mem;
    logic        flush_if2;
    logic        flush_id;
    logic        flush_ex;
    logic        flush_mem;
    logic        flush_wb;
    logic [1:0]  pc_sel;
    logic        dmem_timeout;
    logic [15:0] stall_cycles;
    logic [2:0]  state_o;

    modport master (
        output raw_conflict, imem_ready, dmem_req, dmem_ready, ex_redirect, trap_req, perf_clr,
        input  stall_pc, stall_if2, stall_id, stall_ex, stall_mem,
        input  flush_if2, flush_id, flush_ex, flush_mem, flush_wb,
        input  pc_sel, dmem_timeout, stall_cycles, state_o
    );

    modport slave (
        input  raw_conflict, imem_ready, dmem_req, dmem_ready, ex_redirect, trap_req, perf_clr,
        output stall_pc, stall_if2, stall_id, stall_ex, stall_mem,
        output flush_if2, flush_id, flush_ex, flush_mem, flush_wb,
        output pc_sel, dmem_timeout, stall_cycles, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: prioritised trap / dmem / redirect / RAW / imem handling.
// Stall, flush and pc_sel are combinational from the registered state and current events.
module hazard_ctrl #(
    parameter int unsigned TRAP_LAT     = 2,
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_RAW  = 3'd1;
    localparam logic [2:0] S_DW   = 3'd2;
    localparam logic [2:0] S_TRAP = 3'd3;

    localparam logic [3:0] TRAP_LOAD = 4'(TRAP_LAT);
    localparam logic [7:0] WAIT_LAST = 8'(DMEM_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  trap_cnt_q, trap_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        dmem_timeout_q, dmem_timeout_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic        st_pc, st_if2, st_id, st_ex, st_mem;
    logic        fl_if2, fl_id, fl_ex, fl_mem, fl_wb;
    logic [1:0]  sel;
    logic        dmem_stall;

    assign dmem_stall = hz.dmem_req & ~hz.dmem_ready;

    always_comb begin
        st_pc          = 1'b0;
        st_if2         = 1'b0;
        st_id          = 1'b0;
        st_ex          = 1'b0;
        st_mem         = 1'b0;
        fl_if2         = 1'b0;
        fl_id          = 1'b0;
        fl_ex          = 1'b0;
        fl_mem         = 1'b0;
        fl_wb          = 1'b0;
        sel            = 2'd0;
        state_d        = S_RUN;
        trap_cnt_d     = trap_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        dmem_timeout_d = 1'b0;

        case (state_q)
            S_RUN, S_RAW, S_DW: begin
                if (hz.trap_req) begin
                    sel        = 2'd2;
                    fl_if2     = 1'b1;
                    fl_id      = 1'b1;
                    fl_ex      = 1'b1;
                    fl_mem     = 1'b1;
                    trap_cnt_d = TRAP_LOAD;
                    state_d    = S_TRAP;
                end else if (dmem_stall) begin
                    st_pc   = 1'b1;
                    st_if2  = 1'b1;
                    st_id   = 1'b1;
                    st_ex   = 1'b1;
                    st_mem  = 1'b1;
                    fl_wb   = 1'b1;
                    state_d = S_DW;
                    // Counter restarts on entry; it wraps to 0 on the cycle that raises the pulse.
                    if (state_q != S_DW) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_d     = '0;
                        dmem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else if (hz.ex_redirect) begin
                    sel    = 2'd1;
                    fl_if2 = 1'b1;
                    fl_id  = 1'b1;
                end else if (hz.raw_conflict && state_q != S_RAW) begin
                    st_pc   = 1'b1;
                    st_if2  = 1'b1;
                    fl_ex   = 1'b1;
                    state_d = S_RAW;
                end else if (!hz.imem_ready) begin
                    st_pc  = 1'b1;
                    fl_if2 = 1'b1;
                end
            end
            S_TRAP: begin
                st_pc      = 1'b1;
                fl_if2     = 1'b1;
                fl_id      = 1'b1;
                trap_cnt_d = trap_cnt_q - 4'd1;
                state_d    = (trap_cnt_q > 4'd1) ? S_TRAP : S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        stall_cycles_d = stall_cycles_q;
        if (hz.perf_clr) begin
            stall_cycles_d = '0;
        end else if (st_pc && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RUN;
            trap_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            dmem_timeout_q <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            trap_cnt_q     <= trap_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            dmem_timeout_q <= dmem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Outputs are gated by rst_n so they read 0 during reset whatever the inputs do.
    assign hz.stall_pc     = rst_n & st_pc;
    assign hz.stall_if2    = rst_n & st_if2 & ~fl_if2;
    assign hz.stall_id     = rst_n & st_id & ~fl_id;
    assign hz.stall_ex     = rst_n & st_ex & ~fl_ex;
    assign hz.stall_mem    = rst_n & st_mem & ~fl_mem;
    assign hz.flush_if2    = rst_n & fl_if2;
    assign hz.flush_id     = rst_n & fl_id;
    assign hz.flush_ex     = rst_n & fl_ex;
    assign hz.flush_mem    = rst_n & fl_mem;
    assign hz.flush_wb     = rst_n & fl_wb;
    assign hz.pc_sel       = rst_n ? sel : 2'd0;
    assign hz.dmem_timeout = dmem_timeout_q;
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.state_o      = state_q;
endmodule
